// File: rtl/apb_master_nslv.sv
// APB requester fanning one command/response port out to NUM_SLV address-decoded completers.
// Optional ACCESS-phase watchdog is compiled in with `define APB_TIMEOUT_EN.
module apb_master_nslv #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NUM_SLV     = 4,
  parameter int REGION_LOG2 = 12,
  parameter int TIMEOUT     = 255
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [DW-1:0]         cmd_wdata,
  output logic                  rsp_valid,
  output logic [DW-1:0]         rsp_rdata,
  output logic                  rsp_err,
  output logic [AW-1:0]         PADDR,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DW-1:0]         PWDATA,
  input  logic [NUM_SLV*DW-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  if (NUM_SLV < 1 || NUM_SLV > 16 || TIMEOUT < 1) begin : g_bad_cfg
    $error("apb_master_nslv: NUM_SLV must be 1..16 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state;

  logic [IW-1:0]      slv_idx;
  logic [AW-1:0]      idx_full;
  logic [IW-1:0]      dec_idx;
  logic               dec_ok;
  logic [NUM_SLV-1:0] dec_sel;
  logic               sel_ready;
  logic               sel_err;
  logic [DW-1:0]      sel_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;
`endif

  always_comb begin
    idx_full = cmd_addr >> REGION_LOG2;
    dec_ok   = (idx_full < AW'(NUM_SLV));
    dec_idx  = idx_full[IW-1:0];
    dec_sel  = '0;
    dec_sel[dec_idx] = 1'b1;
  end

  always_comb begin
    sel_ready = PREADY[slv_idx];
    sel_err   = PSLVERR[slv_idx];
    sel_rdata = PRDATA[slv_idx*DW +: DW];
  end

  // A decode-error command is held off at completion so its response never
  // collides with the completing transfer's response in the same cycle.
  always_comb begin
    cmd_ready = 1'b0;
    if (state == IDLE)
      cmd_ready = 1'b1;
    else if (state == ACCESS && sel_ready && (dec_ok || !cmd_valid))
      cmd_ready = 1'b1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      slv_idx   <= '0;
      PSEL      <= '0;
      PENABLE   <= 1'b0;
      PADDR     <= '0;
      PWRITE    <= 1'b0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: ;
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
`ifdef APB_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        ACCESS: begin
          if (sel_ready) begin
            rsp_valid <= 1'b1;
            rsp_err   <= sel_err;
            rsp_rdata <= PWRITE ? '0 : sel_rdata;
            state     <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
          end
`ifdef APB_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT - 1)) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase

      // Acceptance overrides the IDLE return above, giving back-to-back SETUP.
      if (cmd_valid && cmd_ready) begin
        if (dec_ok) begin
          state   <= SETUP;
          slv_idx <= dec_idx;
          PSEL    <= dec_sel;
          PENABLE <= 1'b0;
          PADDR   <= cmd_addr;
          PWRITE  <= cmd_write;
          if (cmd_write)
            PWDATA <= cmd_wdata;
        end else begin
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b1;
          rsp_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_nslv.sv
// Scoreboard bench for apb_master_nslv: stimulus pushes expected responses, a monitor pops and checks them.
module tb_apb_master_nslv;
  localparam int AW = 32, DW = 32, NS = 4;

  logic           PCLK = 1'b0;
  logic           PRESETn;
  logic           cmd_valid, cmd_write, cmd_ready;
  logic [AW-1:0]  cmd_addr;
  logic [DW-1:0]  cmd_wdata;
  logic           rsp_valid, rsp_err;
  logic [DW-1:0]  rsp_rdata;
  logic [AW-1:0]  PADDR;
  logic [NS-1:0]  PSEL, PREADY, PSLVERR;
  logic           PENABLE, PWRITE;
  logic [DW-1:0]  PWDATA;
  logic [NS*DW-1:0] PRDATA;

  apb_master_nslv #(.AW(AW), .DW(DW), .NUM_SLV(NS), .REGION_LOG2(12), .TIMEOUT(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Completer models: non-selected slaves drive ready/error high to prove they are ignored.
  int  waits [NS];
  int  wcnt  [NS];
  bit  errs  [NS];
  assign PRDATA = {32'h33332222, 32'hCAFE0001, 32'h22221111, 32'h11110000};

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      PREADY[i]  = (PSEL[i] && PENABLE) ? (wcnt[i] >= waits[i]) : 1'b1;
      PSLVERR[i] = PSEL[i] ? errs[i] : 1'b1;
    end
  end

  always @(posedge PCLK) begin
    for (int i = 0; i < NS; i++)
      wcnt[i] <= (PSEL[i] && PENABLE && !PREADY[i]) ? wcnt[i] + 1 : 0;
  end

  typedef struct {logic [DW-1:0] rd; logic err; int at;} exp_t;
  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge PCLK) begin
    if (PRESETn === 1'b1 && rsp_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
        chk("rsp_cycle", cyc, e.at);
      end
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] rd, input logic er, input int lat,
                       input bit push, output int acc);
    int n;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    #1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 100) begin
      @(negedge PCLK); #1; n++;
    end
    if (cmd_ready !== 1'b1) chk("accept_timeout", 32'd0, 32'd1);
    acc = cyc;
    if (push) sb.push_back('{rd: rd, err: er, at: cyc + lat});
    @(posedge PCLK); #1;
  endtask

  initial begin
    int acc1, acc2, pen;
    bit stable;
    for (int i = 0; i < NS; i++) begin waits[i] = 0; errs[i] = 1'b0; end
    PRESETn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    #3;
    chk("rst_psel", {28'b0, PSEL}, 32'h0);
    chk("rst_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    #1 chk("idle_ready", {31'b0, cmd_ready}, 32'h1);

    // Zero-wait read of slave 2
    issue(1'b0, 32'h2004, 32'h0, 32'hCAFE0001, 1'b0, 3, 1'b1, acc1);
    chk("setup_psel", {28'b0, PSEL}, 32'h4);
    chk("setup_penable", {31'b0, PENABLE}, 32'h0);
    chk("setup_paddr", PADDR, 32'h2004);
    cmd_valid = 1'b0;
    repeat (4) @(negedge PCLK);

    // Write with 4 wait states on slave 3
    waits[3] = 4;
    issue(1'b1, 32'h3000, 32'hA5A5A5A5, 32'h0, 1'b0, 7, 1'b1, acc1);
    cmd_valid = 1'b0;
    pen = 0; stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge PCLK);
      if (PENABLE) pen++;
      if (PSEL != 0 && PWDATA !== 32'hA5A5A5A5) stable = 1'b0;
    end
    chk("wait_penable_cycles", pen, 5);
    chk("wait_pwdata_stable", {31'b0, stable}, 32'h1);
    chk("idle_psel", {28'b0, PSEL}, 32'h0);
    chk("idle_paddr_held", PADDR, 32'h3000);
    chk("idle_pwdata_held", PWDATA, 32'hA5A5A5A5);
    waits[3] = 0;

    // Back-to-back writes with cmd_valid held
    issue(1'b1, 32'h0000, 32'h11111111, 32'h0, 1'b0, 3, 1'b1, acc1);
    issue(1'b1, 32'h1000, 32'h22222222, 32'h0, 1'b0, 3, 1'b1, acc2);
    chk("b2b_accept_gap", acc2 - acc1, 2);
    chk("b2b_psel", {28'b0, PSEL}, 32'h2);
    chk("b2b_penable", {31'b0, PENABLE}, 32'h0);
    cmd_valid = 1'b0;
    repeat (5) @(negedge PCLK);

    // Decode error
    issue(1'b0, 32'h5000, 32'h0, 32'h0, 1'b1, 1, 1'b1, acc1);
    chk("decerr_psel", {28'b0, PSEL}, 32'h0);
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);

    // Slave error on slave 1
    errs[1] = 1'b1;
    issue(1'b0, 32'h1008, 32'h0, 32'h22221111, 1'b1, 3, 1'b1, acc1);
    cmd_valid = 1'b0;
    repeat (5) @(negedge PCLK);
    errs[1] = 1'b0;

`ifdef APB_TIMEOUT_EN
    waits[1] = 1000;
    issue(1'b0, 32'h1000, 32'h0, 32'h0, 1'b1, 10, 1'b1, acc1);
    cmd_valid = 1'b0;
    repeat (14) @(negedge PCLK);
    chk("timeout_psel", {28'b0, PSEL}, 32'h0);
    waits[1] = 0;
`endif

    // Reset during ACCESS abandons the transfer
    waits[0] = 10;
    issue(1'b0, 32'h0010, 32'h0, 32'h0, 1'b0, 0, 1'b0, acc1);
    cmd_valid = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    chk("pre_rst_access", {31'b0, PENABLE}, 32'h1);
    PRESETn = 1'b0;
    #1;
    chk("rst_mid_psel", {28'b0, PSEL}, 32'h0);
    chk("rst_mid_penable", {31'b0, PENABLE}, 32'h0);
    chk("rst_mid_paddr", PADDR, 32'h0);
    chk("rst_mid_pwdata", PWDATA, 32'h0);
    chk("rst_mid_pwrite", {31'b0, PWRITE}, 32'h0);
    chk("rst_mid_rsp", {rsp_valid, rsp_err, 30'b0}, 32'h0);
    chk("rst_mid_rdata", rsp_rdata, 32'h0);
    repeat (3) @(negedge PCLK);
    PRESETn = 1'b1;
    waits[0] = 0;
    repeat (15) @(negedge PCLK);

    // Resume after reset
    issue(1'b0, 32'h2000, 32'h0, 32'hCAFE0001, 1'b0, 3, 1'b1, acc1);
    cmd_valid = 1'b0;

    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge PCLK);
    repeat (2) @(negedge PCLK);
    chk("sb_drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/apb_master_nslv.md
APB_MASTER_NSLV -- requirements
Module: apb_master_nslv

Interface
REQ-001 SHALL have parameter AW, default 32, APB and command address width.
REQ-002 SHALL have parameter DW, default 32, APB and command data width.
REQ-003 SHALL have parameter NUM_SLV, default 4, number of APB completers (1..16).
REQ-004 SHALL have parameter REGION_LOG2, default 12, log2 of the byte size of each completer's address region.
REQ-005 SHALL have parameter TIMEOUT, default 255, maximum ACCESS wait cycles; used only when APB_TIMEOUT_EN is defined.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: PCLK input 1, clock; PRESETn input 1, reset, asynchronous active-low.
REQ-007 SHALL have the command ports: cmd_valid input 1, request; cmd_ready output 1, accept; cmd_write input 1, 1=write 0=read; cmd_addr input AW, address; cmd_wdata input DW, write data.
REQ-008 SHALL have the response ports: rsp_valid output 1, one-cycle completion pulse; rsp_rdata output DW, read data; rsp_err output 1, error flag.
REQ-009 SHALL have the APB outputs: PADDR output AW; PSEL output NUM_SLV, one-hot select; PENABLE output 1; PWRITE output 1; PWDATA output DW.
REQ-010 SHALL have the APB inputs: PRDATA input NUM_SLV*DW, slice i belongs to completer i; PREADY input NUM_SLV; PSLVERR input NUM_SLV.

Function
REQ-011 SHALL implement states IDLE, SETUP, ACCESS.
REQ-012 SHALL decode slave index = cmd_addr >> REGION_LOG2; index >= NUM_SLV is a decode error.
REQ-013 SHALL drive cmd_ready combinationally high in IDLE, and in ACCESS during the completion cycle (selected PREADY=1); otherwise low; a command is accepted when cmd_valid & cmd_ready.
REQ-014 SHALL, on accepting a decodable command, register PADDR, PWRITE, PWDATA (PWDATA is written only for writes, else it holds) and the one-hot PSEL, then enter SETUP with PENABLE=0.
REQ-015 SHALL go from SETUP to ACCESS unconditionally after one cycle, asserting PENABLE=1 and keeping PADDR/PWRITE/PWDATA/PSEL stable.
REQ-016 SHALL stay in ACCESS while the selected PREADY=0 and ignore the PREADY/PSLVERR of non-selected completers.
REQ-017 SHALL, on the cycle the selected PREADY=1: pulse rsp_valid the next cycle, with rsp_err = selected PSLVERR and rsp_rdata = selected PRDATA slice for reads (0 for writes).
REQ-018 SHALL, at completion, go to SETUP if a new command is accepted in the same cycle (back-to-back, no IDLE gap), else go to IDLE with PSEL=0 and PENABLE=0.
REQ-019 SHALL, on an accepted decode-error command, issue no APB cycle, keep PSEL=0, and pulse rsp_valid=1 with rsp_err=1 and rsp_rdata=0 on the next cycle, remaining in IDLE.
REQ-020 SHALL keep PADDR/PWRITE/PWDATA at their last values in IDLE.
REQ-021 SHALL have minimum latency, from accept to rsp_valid, of 3 cycles for a zero-wait completer and 3+N cycles for N wait states.

Reset
REQ-022 SHALL, with PRESETn low, immediately force: state IDLE; PSEL=0; PENABLE=0; PADDR=0; PWRITE=0; PWDATA=0; rsp_valid=0; rsp_rdata=0; rsp_err=0.
REQ-023 SHALL, on reset mid-transfer, abandon the transfer with no response; operation resumes from IDLE on the first PCLK edge after PRESETn is released.

Configuration
REQ-024 SHALL, with APB_TIMEOUT_EN defined, count ACCESS wait cycles; when TIMEOUT cycles have elapsed with the selected PREADY=0, it drives PSEL=0 and PENABLE=0, goes to IDLE, and pulses rsp_valid with rsp_err=1 and rsp_rdata=0; the counter clears on every SETUP.
REQ-025 SHALL, without APB_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely; the TIMEOUT parameter is then unused.

Verification
REQ-026 SHALL cover a read of addr 0x2004 (slave 2) with a zero-wait completer and PRDATA slice 2=0xCAFE0001 -> PSEL=4'b0100, rsp_valid 3 cycles after accept, rsp_rdata=0xCAFE0001, rsp_err=0.
REQ-027 SHALL cover a write of 0xA5A5A5A5 to 0x3000 with slave 3 holding PREADY low for 4 cycles -> PENABLE high for 5 cycles, PWDATA stable throughout, rsp_valid 7 cycles after accept.
REQ-028 SHALL cover back-to-back writes to 0x0000 then 0x1000 with cmd_valid held -> the second SETUP immediately follows the first ACCESS, with no cycle where PSEL=0.
REQ-029 SHALL cover a read of 0x5000 (NUM_SLV=4) -> PSEL stays 0 and rsp_valid=1 with rsp_err=1 and rsp_rdata=0 one cycle after accept.
REQ-030 SHALL cover PSLVERR on slave 1, and reset asserted during an ACCESS -> the first gives rsp_err=1; the second gives all outputs 0 immediately and no rsp_valid.
REQ-031 SHALL cover, with APB_TIMEOUT_EN and TIMEOUT=8, PREADY held low -> abort after 8 wait cycles with rsp_err=1.
